// File: rtl/adder4b.sv
// rtl/adder4b.sv - 4-bit unsigned adder with carry-out as bit 4 of the sum
module adder4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [4:0] S
);

    assign S = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/mult4b_seq.sv
// rtl/mult4b_seq.sv - sequential 4x4 unsigned shift-and-add multiplier, 8-bit product
// One partial product is added per CALC cycle through a single adder4b.
// The 9-bit accumulator {carry, hi, lo} is shifted right after every add.
// As a result, the adder carry lands in hi[3] and the carry register is never needed.
module mult4b_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] mcand;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] cnt;
    logic [3:0] add_b;
    logic [4:0] sum;

    // The multiplier LSB currently in lo[0] selects whether the multiplicand is added.
    assign add_b = lo[0] ? mcand : 4'b0000;

    adder4b u_adder (
        .A (hi),
        .B (add_b),
        .S (sum)
    );

    // Control FSM and datapath registers.
    // busy/done are registered alongside the state so they change only on state changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mcand <= 4'd0;
            hi    <= 4'd0;
            lo    <= 4'd0;
            cnt   <= 2'd0;
            P     <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= A;
                        hi    <= 4'd0;
                        lo    <= B;
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // {carry, hi, lo} <= {sum, lo} >> 1
                    hi  <= sum[4:1];
                    lo  <= {sum[0], lo[3:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        P     <= {sum[4:1], sum[0], lo[3:1]};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
